la_spmem_adapter: RTL and testbench

LA_SPMEM_ADAPTER -- requirements
Module: la_spmem_adapter

---
 rtl/la_spmem_if.sv | 38 +++
 rtl/la_spmem_adapter.sv | 70 +++++++
 tb/tb_la_spmem_adapter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/la_spmem_if.sv
// Bundles the request, response and memory-side signals of the single-port memory adapter.
// The slave modport is the adapter's view; the master modport is the client/memory side.
interface la_spmem_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_wmask;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_ce, mem_we, mem_addr, mem_din, mem_wmask
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        output rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_ce, mem_we, mem_addr, mem_din, mem_wmask
    );
endinterface

// File: rtl/la_spmem_adapter.sv
// Valid/ready front end for a single-port synchronous RAM with one-cycle read latency.
// Read data is always captured into a 2-entry skid FIFO, so back-pressure never loses a read.
module la_spmem_adapter #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    la_spmem_if.slave   bus
);
    logic          accept;
    logic          pop;
    logic          inflight_reg;
    logic          inflight_next;
    logic [1:0]    occ_reg;
    logic [1:0]    occ_next;
    logic [1:0]    pending;
    logic          wptr_reg;
    logic          rptr_reg;
    logic [DW-1:0] entry_reg [2];

    assign accept = bus.req_valid & bus.req_ready;
    assign pop    = bus.rsp_valid & bus.rsp_ready;

    // Reads in the RAM pipeline count against FIFO space so a capture always finds a free slot.
    assign pending       = occ_reg + {1'b0, inflight_reg};
    assign bus.req_ready = ~reset & ((pending < 2'd2) | pop);

    assign bus.mem_ce    = accept;
    assign bus.mem_we    = accept & bus.req_write;
    assign bus.mem_addr  = bus.req_addr;
    assign bus.mem_din   = bus.req_wdata;
    assign bus.mem_wmask = bus.req_wmask;

    assign bus.rsp_valid = (occ_reg != 2'd0);
    assign bus.rsp_rdata = bus.rsp_valid ? entry_reg[rptr_reg] : '0;

    always_comb begin
        inflight_next = accept & ~bus.req_write;
        occ_next      = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_reg <= 1'b0;
            occ_reg      <= 2'd0;
            wptr_reg     <= 1'b0;
            rptr_reg     <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            occ_reg      <= occ_next;
            if (inflight_reg) begin
                wptr_reg <= ~wptr_reg;
            end
            if (pop) begin
                rptr_reg <= ~rptr_reg;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                entry_reg[gi] <= '0;
            end else if (inflight_reg && (wptr_reg == 1'(gi))) begin
                entry_reg[gi] <= bus.mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_la_spmem_adapter.sv
// Scoreboard bench for la_spmem_adapter: a reference memory predicts read data at accept time,
// and an independent monitor compares every delivered response in order.
module tb_la_spmem_adapter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    la_spmem_if #(.DW(DW), .AW(AW)) bus ();
    la_spmem_adapter #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] ram [1 << AW];
    logic [DW-1:0] ram_dout = '0;

    // Synchronous RAM device attached to the memory port.
    assign bus.mem_dout = ram_dout;
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we)
                ram[bus.mem_addr] <= (ram[bus.mem_addr] & ~bus.mem_wmask) | (bus.mem_din & bus.mem_wmask);
            else
                ram_dout <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: in-order response check, stall stability, empty-data rule, occupancy bound.
    int cyc = 0;
    int pop_count = 0;
    int last_pop_cyc = -10;
    int run_len = 0;
    logic [DW-1:0] last_rdata = '0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (!bus.rsp_valid) check("rdata_empty_zero", bus.rsp_rdata, 0);
            if (prev_stall) begin
                check("stall_valid_hold", bus.rsp_valid, 1);
                check("stall_data_hold", bus.rsp_rdata, prev_data);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 1, 0);
                end else begin
                    check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
                end
                run_len = (last_pop_cyc == cyc - 1) ? run_len + 1 : 1;
                last_pop_cyc = cyc;
                last_rdata = bus.rsp_rdata;
                pop_count++;
                $display("rsp  cyc=%0d data=%08h", cyc, bus.rsp_rdata);
            end
            check("occ_max", (dut.occ_reg <= 2'd2), 1);
            prev_stall = bus.rsp_valid & ~bus.rsp_ready;
            prev_data = bus.rsp_rdata;
        end
    end

    task automatic do_cycle(input bit v, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m,
                            input bit rr, output bit acc);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        bus.rsp_ready = rr;
        @(negedge clk);
        acc = v & bus.req_ready;
        if (acc) begin
            check("mem_ce", bus.mem_ce, 1);
            check("mem_we", bus.mem_we, w);
            check("mem_addr", bus.mem_addr, a);
            if (w) begin
                ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            end else begin
                exp_q.push_back(ref_mem[a]);
            end
            $display("req  cyc=%0d %s addr=%03h data=%08h mask=%08h", cyc, w ? "WR" : "RD", a, d, m);
        end else if (!v) begin
            check("mem_ce_idle", bus.mem_ce, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) do_cycle(0, 0, '0, '0, '0, 1, acc);
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 20) begin
            do_cycle(1, w, a, d, m, 1, acc);
            tries++;
        end
        check("issue_accepted", acc, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int acc_n;
        int pc;
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = $urandom;
            ram[i] = v;
            ref_mem[i] = v;
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b1;

        // Reset state with a request pending at the input.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_mem_ce", bus.mem_ce, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // Write then read same address on the next cycle; response two cycles after the read.
        do_cycle(1, 1, 10'h005, 32'hA5A5A5A5, 32'hFFFFFFFF, 1, acc);
        check("wr5_accept", acc, 1);
        do_cycle(1, 0, 10'h005, '0, '0, 1, acc);
        check("rd5_accept", acc, 1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rd5_latency1_valid", bus.rsp_valid, 0);
        @(negedge clk);
        check("rd5_latency2_valid", bus.rsp_valid, 1);
        @(posedge clk);
        #1;
        idle(3);
        check("rd5_data", last_rdata, 32'hA5A5A5A5);

        // Sixteen back-to-back reads with the consumer always ready.
        pc = pop_count;
        for (int i = 0; i < 16; i++) begin
            do_cycle(1, 0, AW'(i), '0, '0, 1, acc);
            check("b2b_accept", acc, 1);
        end
        idle(5);
        check("b2b_count", pop_count - pc, 16);
        check("b2b_consecutive", run_len, 16);

        // Back-pressure: only two reads fit, then release.
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(1, 0, AW'(20 + i), '0, '0, 0, acc);
            acc_n += int'(acc);
        end
        check("bp_accepts", acc_n, 2);
        check("bp_ready_low", bus.req_ready, 0);
        pc = pop_count;
        idle(4);
        check("bp_drain_count", pop_count - pc, 2);
        check("bp_ready_back", bus.req_ready, 1);

        // Partial write mask.
        issue(1, 10'h007, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(1, 10'h007, 32'h12345678, 32'h0000FFFF);
        issue(0, 10'h007, '0, '0);
        idle(4);
        check("mask_data", last_rdata, 32'hFFFF5678);

        // Reset one cycle after an accepted read: the read must vanish.
        idle(2);
        do_cycle(1, 0, 10'h009, '0, '0, 1, acc);
        check("rst_rd_accept", acc, 1);
        reset = 1'b1;
        exp_q.delete();
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_mem_ce", bus.mem_ce, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_rst_valid", bus.rsp_valid, 0);
            check("after_rst_ready", bus.req_ready, 1);
            check("after_rst_occ", dut.occ_reg, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic over a small address window to provoke hazards.
        for (int i = 0; i < 10000; i++) begin
            do_cycle(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 32), $urandom,
                     ($urandom % 2) ? '1 : DW'($urandom), ($urandom % 3) != 0, acc);
        end
        idle(20);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
